key_input_conditioner: RTL and testbench

Front-end stage between the board's raw pushbuttons/switches and the piano, auto-play and learning controllers. It synchronises every raw key input to `clk`, debounces each one independently, and produces clean levels, single-cycle press pulses and a priority-encoded note code. The downstream controllers consume these outputs directly; none of them sees raw pin inputs.

---
 rtl/key_input_conditioner.sv | 115 +++++++++++
 tb/tb_key_input_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Purpose: synchronise, debounce and encode raw pushbutton/switch inputs (7 keys, 2 octave, next, prev).
// Latency: a raw change sampled at edge k shows on the outputs at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; outputs are free-running levels and one-cycle pulses.
module key_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] key_raw,
    input  logic [1:0] octave_raw,
    input  logic       next_raw,
    input  logic       prev_raw,
    output logic [6:0] key_level,
    output logic [6:0] key_press,
    output logic [2:0] note,
    output logic       note_valid,
    output logic [1:0] octave_level,
    output logic       next_pulse,
    output logic       prev_pulse
);

    // Channel map: [6:0] note keys, [8:7] octave, [9] next, [10] prev.
    localparam int NCH = 11;
    localparam int CH_NEXT = 9;
    localparam int CH_PREV = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0] raw_all;
    assign raw_all = {prev_raw, next_raw, octave_raw, key_raw};

    logic [NCH-1:0]            sync1_q, sync1_d;
    logic [NCH-1:0]            sync2_q, sync2_d;
    logic [NCH-1:0]            stable_q, stable_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            rise;

    logic [6:0] key_press_q, key_press_d;
    logic [2:0] note_q, note_d;
    logic       note_valid_q, note_valid_d;
    logic       next_pulse_q, next_pulse_d;
    logic       prev_pulse_q, prev_pulse_d;

    // Per-channel debounce: a channel is counting exactly while its synchronised
    // value differs from its stable bit, so IDLE/COUNT needs no separate state flop.
    // Any return to the stable value restarts the count from zero.
    always_comb begin
        sync1_d  = raw_all;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int c = 0; c < NCH; c++) begin
            if (sync2_q[c] == stable_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_LAST) begin
                stable_d[c] = ~stable_q[c];
                cnt_d[c]    = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    // Registered outputs are derived from the next stable value so that levels,
    // pulses and the note code all change on the same edge.
    always_comb begin
        rise         = stable_d & ~stable_q;
        key_press_d  = rise[6:0];
        note_valid_d = |stable_d[6:0];
        note_d       = '0;
        // Scan high to low so the lowest held key is the last writer and wins.
        for (int i = 6; i >= 0; i--) begin
            if (stable_d[i]) begin
                note_d = 3'(i + 1);
            end
        end
        // A simultaneous next+prev press is ambiguous, so neither is reported.
        next_pulse_d = rise[CH_NEXT] & ~rise[CH_PREV];
        prev_pulse_d = rise[CH_PREV] & ~rise[CH_NEXT];
    end

    // State and output registers; reset aborts any count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            cnt_q        <= '0;
            key_press_q  <= '0;
            note_q       <= '0;
            note_valid_q <= 1'b0;
            next_pulse_q <= 1'b0;
            prev_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            key_press_q  <= key_press_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
            next_pulse_q <= next_pulse_d;
            prev_pulse_q <= prev_pulse_d;
        end
    end

    assign key_level    = stable_q[6:0];
    assign octave_level = stable_q[8:7];
    assign key_press    = key_press_q;
    assign note         = note_q;
    assign note_valid   = note_valid_q;
    assign next_pulse   = next_pulse_q;
    assign prev_pulse   = prev_pulse_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios followed by random input activity.
// Expected outputs come from a sample-window model and are checked cycle by cycle via a queue.
// Reset forces the expected outputs to zero while it is high.
module tb_key_input_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [6:0] key_raw;
    logic [1:0] octave_raw;
    logic       next_raw;
    logic       prev_raw;
    logic [6:0] key_level;
    logic [6:0] key_press;
    logic [2:0] note;
    logic       note_valid;
    logic [1:0] octave_level;
    logic       next_pulse;
    logic       prev_pulse;

    typedef struct packed {
        logic [6:0] lvl;
        logic [6:0] prs;
        logic [2:0] nt;
        logic       nv;
        logic [1:0] oct;
        logic       np;
        logic       pp;
    } out_t;

    out_t        exp_q[$];
    logic [10:0] hist[$];
    logic [10:0] m_stable;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          next_cnt = 0;
    int          prev_cnt = 0;

    key_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .octave_raw   (octave_raw),
        .next_raw     (next_raw),
        .prev_raw     (prev_raw),
        .key_level    (key_level),
        .key_press    (key_press),
        .note         (note),
        .note_valid   (note_valid),
        .octave_level (octave_level),
        .next_pulse   (next_pulse),
        .prev_pulse   (prev_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stable value of a channel flips at edge t when the raw
    // samples taken at edges t-2 .. t-1-D all disagree with it. hist[0] is the raw
    // sample of the previous edge.
    always @(posedge clk) begin
        out_t        e;
        logic [10:0] raw;
        logic [10:0] nstable;
        logic [10:0] rise;
        logic        all_diff;
        int          lowest;
        raw = {prev_raw, next_raw, octave_raw, key_raw};
        e   = '0;
        if (reset) begin
            m_stable = '0;
            hist     = {};
            for (int i = 0; i < D + 2; i++) hist.push_back(11'h0);
        end else begin
            nstable = m_stable;
            for (int c = 0; c < 11; c++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
                end
                if (all_diff) nstable[c] = ~m_stable[c];
            end
            rise = nstable & ~m_stable;
            hist.push_front(raw);
            void'(hist.pop_back());
            lowest = 0;
            for (int i = 6; i >= 0; i--) begin
                if (nstable[i]) lowest = i + 1;
            end
            e.lvl    = nstable[6:0];
            e.prs    = rise[6:0];
            e.nt     = 3'(lowest);
            e.nv     = (nstable[6:0] != 7'h00);
            e.oct    = nstable[8:7];
            e.np     = rise[9] && !rise[10];
            e.pp     = rise[10] && !rise[9];
            m_stable = nstable;
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle the DUT presents its outputs; compare against the queue head.
    always @(negedge clk) begin
        out_t a;
        out_t e;
        a = {key_level, key_press, note, note_valid, octave_level, next_pulse, prev_pulse};
        if (next_pulse) next_cnt++;
        if (prev_pulse) prev_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow at %0t: got %h, expected an entry", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (reset) e = '0;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs at %0t: got lvl=%h prs=%h note=%0d nv=%b oct=%b np=%b pp=%b, expected lvl=%h prs=%h note=%0d nv=%b oct=%b np=%b pp=%b",
                         $time, a.lvl, a.prs, a.nt, a.nv, a.oct, a.np, a.pp,
                         e.lvl, e.prs, e.nt, e.nv, e.oct, e.np, e.pp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        reset      = 1'b1;
        key_raw    = 7'h7F;
        octave_raw = 2'b00;
        next_raw   = 1'b0;
        prev_raw   = 1'b0;
        tick(3);

        // Release reset with key 0 held: level, press and note 1 after the full latency.
        key_raw = 7'h01;
        reset   = 1'b0;
        tick(12);
        key_raw = 7'h00;
        tick(12);

        // Short glitch on key 3 is rejected.
        key_raw = 7'h08;
        tick(3);
        key_raw = 7'h00;
        tick(10);

        // Two keys held: lowest wins; releasing it moves the note without a press.
        key_raw = 7'h14;
        tick(10);
        key_raw = 7'h10;
        tick(10);
        key_raw = 7'h00;
        tick(10);

        // Long next hold: exactly one pulse.
        next_cnt = 0;
        next_raw = 1'b1;
        tick(100);
        check_count("next_hold_pulses", next_cnt, 1);
        next_raw = 1'b0;
        tick(10);

        // Simultaneous next and prev: both suppressed.
        next_cnt = 0;
        prev_cnt = 0;
        next_raw = 1'b1;
        prev_raw = 1'b1;
        tick(12);
        check_count("simul_next_pulses", next_cnt, 0);
        check_count("simul_prev_pulses", prev_cnt, 0);
        next_raw = 1'b0;
        prev_raw = 1'b0;
        tick(10);

        // Reset in the middle of a count restarts it.
        key_raw = 7'h01;
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        key_raw = 7'h00;
        tick(10);

        // Held key with a chattering input: level holds until the input settles low.
        key_raw = 7'h01;
        tick(10);
        for (int i = 0; i < 20; i++) begin
            key_raw[0] = ~key_raw[0];
            tick(2);
        end
        key_raw = 7'h00;
        tick(10);

        // Random activity on all channels, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 7; b++) begin
                if ($urandom_range(11) == 0) key_raw[b] = ~key_raw[b];
            end
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(11) == 0) octave_raw[b] = ~octave_raw[b];
            end
            if ($urandom_range(11) == 0) next_raw = ~next_raw;
            if ($urandom_range(11) == 0) prev_raw = ~prev_raw;
            if ($urandom_range(399) == 0) begin
                reset = 1'b1;
                tick(1 + $urandom_range(2));
                reset = 1'b0;
            end
            tick(1);
        end

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
